// File: rtl/timer_cmd_tx.sv
// Serial command initiator for the pattern-triggered delay timer: sends {PATTERN, delay} MSB first,
// waits for done, answers with a one-cycle ack. Optional watchdog enabled by TIMER_TX_TIMEOUT_EN.
module timer_cmd_tx #(
  parameter int               PAT_W   = 4,
  parameter int               DELAY_W = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
  parameter int               TIMEOUT = 20000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [DELAY_W-1:0] delay,
  input  logic               counting,
  input  logic               done,
  output logic               data,
  output logic               ack,
  output logic               busy,
  output logic               complete,
  output logic               timeout
);

  localparam int FW = PAT_W + DELAY_W;
  localparam int IW = $clog2(FW);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, ACK} state_t;

  state_t             state;
  logic [DELAY_W-1:0] delay_q;
  logic [IW-1:0]      idx;
  logic [IW-1:0]      idx_nxt;
  logic               seen_cnt;
  logic [FW-1:0]      frame;

  assign frame   = {PATTERN, delay_q};
  assign idx_nxt = idx - 1'b1;

`ifdef TIMER_TX_TIMEOUT_EN
  localparam logic [14:0] WD_LAST = 15'(TIMEOUT - 1);
  logic [14:0] wdog;
`else
  logic unused_timeout_param;
  assign unused_timeout_param = (TIMEOUT == 0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      delay_q  <= '0;
      idx      <= '0;
      seen_cnt <= 1'b0;
      data     <= 1'b0;
      ack      <= 1'b0;
      busy     <= 1'b0;
      complete <= 1'b0;
      timeout  <= 1'b0;
`ifdef TIMER_TX_TIMEOUT_EN
      wdog     <= '0;
`endif
    end else begin
      ack      <= 1'b0;
      complete <= 1'b0;
      timeout  <= 1'b0;
      case (state)
        IDLE: begin
          data <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            delay_q  <= delay;
            idx      <= IW'(FW - 1);
            data     <= PATTERN[PAT_W-1];
            busy     <= 1'b1;
            seen_cnt <= 1'b0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (idx == '0) begin
            data  <= 1'b0;
            state <= WAIT_DONE;
`ifdef TIMER_TX_TIMEOUT_EN
            wdog  <= '0;
`endif
          end else begin
            idx  <= idx_nxt;
            data <= frame[idx_nxt];
          end
        end
        WAIT_DONE: begin
          if (counting) seen_cnt <= 1'b1;
          // seen_cnt is registered, so a done left over from a prior command cannot complete this one
          if (seen_cnt && done) begin
            ack      <= 1'b1;
            complete <= 1'b1;
            state    <= ACK;
          end
`ifdef TIMER_TX_TIMEOUT_EN
          else if (wdog == WD_LAST) begin
            timeout  <= 1'b1;
            busy     <= 1'b0;
            seen_cnt <= 1'b0;
            state    <= IDLE;
          end else begin
            wdog <= wdog + 15'd1;
          end
`endif
        end
        ACK: begin
          busy     <= 1'b0;
          seen_cnt <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
